tog_pulse_gen: RTL and testbench

Upstream stimulus stage for the T flip-flop stage. Generates single-cycle toggle-request pulses on t_out, which drive the T flip-flop's t input, at a programmable period. Runs either for a programmed pulse count or continuously. Start/stop command interface with busy/done status.

---
 rtl/tog_pkg.sv | 13 +
 rtl/tog_period_cnt.sv | 32 +++
 rtl/tog_pulse_gen.sv | 125 ++++++++++++
 tb/tb_tog_pulse_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tog_pkg.sv
// Shared state encodings and default widths for the toggle-pulse generator.
package tog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } tog_state_e;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned PC_W_DEF  = 8;

endpackage

// File: rtl/tog_period_cnt.sv
// Loadable down-counter with a zero flag; paces the gap between toggle pulses.
module tog_period_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;

  // Load takes priority over decrement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tog_pulse_gen.sv
// Programmable single-cycle toggle-request pulse generator with start/stop control.
// Define TOG_QMODEL_EN to add q_model, a reference copy of the downstream T flip-flop state.
module tog_pulse_gen
  import tog_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned PC_W  = PC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic [PC_W-1:0]  num_pulses,
  output logic             t_out,
  output logic             busy,
  output logic             done,
  output logic [PC_W-1:0]  pulses_sent
`ifdef TOG_QMODEL_EN
  ,
  output logic             q_model
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

  tog_state_e       state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [PC_W-1:0]  n_q, n_d;
  logic [PC_W-1:0]  sent_q, sent_d;

  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt_val;
  logic [CNT_W-1:0] per_eff;
  logic             pulse;

  assign per_eff = (period == '0) ? CNT_ONE : period;
  // Registered state and counter only, so t_out has no input-to-output path.
  assign pulse   = (state_q == ST_RUN) && cnt_zero;

  tog_period_cnt #(
    .W (CNT_W)
  ) u_period_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    per_d        = per_q;
    n_d          = n_q;
    sent_d       = sent_q;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = per_q - CNT_ONE;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          per_d        = per_eff;
          n_d          = num_pulses;
          sent_d       = '0;
          cnt_load     = 1'b1;
          cnt_load_val = per_eff - CNT_ONE;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pulse) begin
          cnt_load = 1'b1;
          sent_d   = sent_q + PC_ONE;
        end else begin
          cnt_en = 1'b1;
        end
        // Abort beats completion: a final pulse coinciding with stop gives no done.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pulse && (n_q != '0) && ((sent_q + PC_ONE) == n_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      per_q   <= '0;
      n_q     <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      n_q     <= n_d;
      sent_q  <= sent_d;
    end
  end

  assign t_out       = pulse;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign pulses_sent = sent_q;

`ifdef TOG_QMODEL_EN
  logic q_model_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_model_q <= 1'b0;
    end else if (pulse) begin
      q_model_q <= ~q_model_q;
    end
  end

  assign q_model = q_model_q;
`endif

endmodule

// File: tb/tb_tog_pulse_gen.sv
// Scoreboard bench for tog_pulse_gen: expected pulse/done events are queued, a monitor checks them.
module tb_tog_pulse_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] period = 8'd0;
  logic [7:0] num_pulses = 8'd0;
  logic       t_out, busy, done;
  logic [7:0] pulses_sent;
`ifdef TOG_QMODEL_EN
  logic       q_model;
  logic       tff_q;
`endif

  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  typedef struct {
    bit          is_done;
    int unsigned at;
    int unsigned sent;
  } ev_t;

  ev_t exp_q[$];

  tog_pulse_gen #(
    .CNT_W (8),
    .PC_W  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .period      (period),
    .num_pulses  (num_pulses),
    .t_out       (t_out),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent)
`ifdef TOG_QMODEL_EN
    ,
    .q_model     (q_model)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef TOG_QMODEL_EN
  // Downstream T flip-flop driven by t_out.
  always @(posedge clk) begin
    if (!rst) tff_q <= 1'b0;
    else if (t_out) tff_q <= ~tff_q;
  end
`endif

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Finite run accepted at edge s: pulse k during cycle s+k*p-1, done during cycle s+n*p.
  task automatic push_run(input int unsigned s, input int unsigned p, input int unsigned n);
    for (int k = 1; k <= int'(n); k++) begin
      exp_q.push_back('{is_done: 1'b0, at: s + k * p - 1, sent: (k - 1) % 256});
    end
    exp_q.push_back('{is_done: 1'b1, at: s + n * p, sent: n % 256});
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (t_out || done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got t_out=%0b done=%0b sent=%0d at cyc %0d, want none",
                 t_out, done, pulses_sent, cyc);
      end else begin
        e = exp_q.pop_front();
        total++;
        if ((done != e.is_done) || (t_out == done) || (cyc != e.at) || (pulses_sent != e.sent)) begin
          bad++;
          $display("FAIL event: got t_out=%0b done=%0b sent=%0d cyc=%0d, want done=%0b sent=%0d cyc=%0d",
                   t_out, done, pulses_sent, cyc, e.is_done, e.sent, e.at);
        end
      end
    end
`ifdef TOG_QMODEL_EN
    check("q_model", q_model, tff_q);
`endif
  end

  task automatic do_run(input int unsigned per_in, input int unsigned n_in, input bit noise);
    int unsigned p, s;
    p = (per_in == 0) ? 1 : per_in;
    period = per_in[7:0];
    num_pulses = n_in[7:0];
    start = 1'b1;
    tick();
    s = cyc;
    start = 1'b0;
    push_run(s, p, n_in);
    while (cyc < s + n_in * p + 1) begin
      check("busy_run", busy, (cyc < s + n_in * p) ? 1 : 0);
      if (noise) begin
        start = ($urandom % 3 == 0);
        period = 8'd7;
        num_pulses = 8'($urandom);
      end
      tick();
    end
    start = 1'b0;
    check("sent_hold", pulses_sent, n_in % 256);
    check("idle_busy", busy, 0);
    tick();
    check("sent_hold2", pulses_sent, n_in % 256);
  endtask

  // Continuous run, stop raised during the cycle of pulse npulses.
  task automatic do_cont(input int unsigned per_in, input int unsigned npulses);
    int unsigned p, s;
    p = (per_in == 0) ? 1 : per_in;
    period = per_in[7:0];
    num_pulses = 8'd0;
    start = 1'b1;
    tick();
    s = cyc;
    start = 1'b0;
    for (int k = 1; k <= int'(npulses); k++) begin
      exp_q.push_back('{is_done: 1'b0, at: s + k * p - 1, sent: (k - 1) % 256});
    end
    while (cyc < s + npulses * p - 1) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    check("stop_sent", pulses_sent, npulses % 256);
  endtask

  initial begin
    int unsigned s;
    // Reset held with start asserted.
    rst = 1'b0;
    start = 1'b1;
    period = 8'd3;
    num_pulses = 8'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_t_out", t_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sent", pulses_sent, 0);
    end
    start = 1'b0;
    rst = 1'b1;
    tick();

    do_run(3, 4, 1'b0);
    do_run(0, 5, 1'b0);
    do_run(1, 1, 1'b0);
    do_run(2, 3, 1'b1);
    do_cont(2, 11);
    do_cont(1, 260);

    // start+stop together in IDLE: stop wins.
    period = 8'd1;
    num_pulses = 8'd2;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("race_busy", busy, 0);
      tick();
    end

    // Reset mid-run.
    period = 8'd3;
    num_pulses = 8'd10;
    start = 1'b1;
    tick();
    s = cyc;
    start = 1'b0;
    exp_q.push_back('{is_done: 1'b0, at: s + 2, sent: 0});
    exp_q.push_back('{is_done: 1'b0, at: s + 5, sent: 1});
    while (cyc < s + 6) tick();
    rst = 1'b0;
    tick();
    check("mrst_t_out", t_out, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_sent", pulses_sent, 0);
    rst = 1'b1;
    tick();

    for (int r = 0; r < 8; r++) begin
      do_run($urandom_range(0, 5), $urandom_range(1, 6), $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
